dmem_arbiter: RTL

Two-requester arbiter and sequencer in front of the single-port data memory. It shares the memory between the core load/store unit (`core_*`) and the DMA/debug loader (`dma_*`) using round-robin grant. Each accepted request is registered into a one-stage access slot that drives the memory port. Range and type violations are checked before any memory access, and one response per request is returned with fixed latency.

---
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter.
// One instance per requester (core load/store unit, DMA/debug loader).
//   req       request valid, held with fields stable until gnt
//   we        1 = store, 0 = load
//   addr      word address
//   wdata     store data
//   acc_type  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   gnt       combinational accept strobe for the current rising edge
//   rsp_valid one-cycle response pulse, 2 cycles after the grant edge
//   rsp_data  load data (0 for stores and errors)
//   rsp_err   error flag, valid with rsp_valid
// modport master: the requester; modport slave: the arbiter.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  acc_type;
    logic        gnt;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req, we, addr, wdata, acc_type,
        input  gnt, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req, we, addr, wdata, acc_type,
        output gnt, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and one-stage access sequencer in front
// of the single-port data memory.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   core, dma  requester bundles (dmem_arbiter_if.slave)
//   Mem_addr   word address to memory
//   Wrt_data   store data to memory
//   MemWrt     memory write strobe
//   MemRead    memory read strobe
//   mem_type   access type to memory
//   Read_data  combinational read data from memory
// A grant at edge T/T+1 loads the access slot; the slot drives the memory
// during T+1 and the response is registered at edge T+1/T+2, so rsp_valid
// is high in cycle T+2 for every request.
module dmem_arbiter #(
    parameter int addr_width = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     core,
    dmem_arbiter_if.slave     dma,
    output logic [31:0]       Mem_addr,
    output logic [31:0]       Wrt_data,
    output logic              MemWrt,
    output logic              MemRead,
    output logic [2:0]        mem_type,
    input  logic [31:0]       Read_data
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DMA  = 1'b1;

    // Slot and arbitration state
    logic [0:0]  state_reg;
    logic        owner_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  type_reg;
    logic        err_reg;
    logic        last_grant_reg;

    // Response registers
    logic        core_rsp_valid_reg;
    logic [31:0] core_rsp_data_reg;
    logic        core_rsp_err_reg;
    logic        dma_rsp_valid_reg;
    logic [31:0] dma_rsp_data_reg;
    logic        dma_rsp_err_reg;

    // Combinational arbitration and slot-load values
    logic        core_gnt_c;
    logic        dma_gnt_c;
    logic        any_gnt_c;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_type;
    logic        err_next;
    logic [0:0]  state_next;
    logic        slot_active;
    logic [31:0] rsp_data_next;

    // Requests are ignored while reset is held so gnt reads 0 in reset.
    // On a conflict the requester that was not granted last wins.
    always_comb begin
        core_gnt_c = rst_n && core.req && (!dma.req || (last_grant_reg == OWNER_DMA));
        dma_gnt_c  = rst_n && dma.req && !core_gnt_c;
        any_gnt_c  = core_gnt_c || dma_gnt_c;
    end

    assign core.gnt = core_gnt_c;
    assign dma.gnt  = dma_gnt_c;

    always_comb begin
        if (dma_gnt_c) begin
            sel_we    = dma.we;
            sel_addr  = dma.addr;
            sel_wdata = dma.wdata;
            sel_type  = dma.acc_type;
        end else begin
            sel_we    = core.we;
            sel_addr  = core.addr;
            sel_wdata = core.wdata;
            sel_type  = core.acc_type;
        end
    end

    // Range and type legality, decided once at acceptance time so the
    // memory port never sees an illegal access.
    always_comb begin
        err_next = 1'b0;
        if ((sel_addr >> addr_width) != 32'd0) begin
            err_next = 1'b1;
        end
        if ((sel_type == 3'b011) || (sel_type == 3'b110) || (sel_type == 3'b111)) begin
            err_next = 1'b1;
        end
        if (sel_we && ((sel_type == 3'b100) || (sel_type == 3'b101))) begin
            err_next = 1'b1;
        end
    end

    // Back-to-back grants keep the slot in ACCESS; otherwise it drains.
    always_comb begin
        state_next = any_gnt_c ? ACCESS : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_CORE;
            we_reg         <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            type_reg       <= 3'd0;
            err_reg        <= 1'b0;
            last_grant_reg <= OWNER_DMA;
        end else begin
            state_reg <= state_next;
            if (any_gnt_c) begin
                owner_reg      <= dma_gnt_c ? OWNER_DMA : OWNER_CORE;
                we_reg         <= sel_we;
                addr_reg       <= sel_addr;
                wdata_reg      <= sel_wdata;
                type_reg       <= sel_type;
                err_reg        <= err_next;
                last_grant_reg <= dma_gnt_c ? OWNER_DMA : OWNER_CORE;
            end
        end
    end

    // Memory port: only an error-free occupied slot reaches the memory.
    // Because state_reg clears asynchronously, MemWrt drops as soon as
    // reset asserts and an in-flight store never commits.
    always_comb begin
        slot_active = (state_reg == ACCESS) && !err_reg;
        MemWrt      = slot_active && we_reg;
        MemRead     = slot_active && !we_reg;
        Mem_addr    = slot_active ? addr_reg  : 32'd0;
        Wrt_data    = slot_active ? wdata_reg : 32'd0;
        mem_type    = slot_active ? type_reg  : 3'd0;
    end

    always_comb begin
        rsp_data_next = (MemRead) ? Read_data : 32'd0;
    end

    // Response for the slot occupant, registered at the end of its ACCESS
    // cycle; the non-owner's response outputs stay at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rsp_valid_reg <= 1'b0;
            core_rsp_data_reg  <= 32'd0;
            core_rsp_err_reg   <= 1'b0;
            dma_rsp_valid_reg  <= 1'b0;
            dma_rsp_data_reg   <= 32'd0;
            dma_rsp_err_reg    <= 1'b0;
        end else begin
            core_rsp_valid_reg <= 1'b0;
            core_rsp_data_reg  <= 32'd0;
            core_rsp_err_reg   <= 1'b0;
            dma_rsp_valid_reg  <= 1'b0;
            dma_rsp_data_reg   <= 32'd0;
            dma_rsp_err_reg    <= 1'b0;
            if (state_reg == ACCESS) begin
                if (owner_reg == OWNER_DMA) begin
                    dma_rsp_valid_reg <= 1'b1;
                    dma_rsp_data_reg  <= rsp_data_next;
                    dma_rsp_err_reg   <= err_reg;
                end else begin
                    core_rsp_valid_reg <= 1'b1;
                    core_rsp_data_reg  <= rsp_data_next;
                    core_rsp_err_reg   <= err_reg;
                end
            end
        end
    end

    assign core.rsp_valid = core_rsp_valid_reg;
    assign core.rsp_data  = core_rsp_data_reg;
    assign core.rsp_err   = core_rsp_err_reg;
    assign dma.rsp_valid  = dma_rsp_valid_reg;
    assign dma.rsp_data   = dma_rsp_data_reg;
    assign dma.rsp_err    = dma_rsp_err_reg;

endmodule
